pb_debounce_multi: RTL and testbench
====================================

PB_DEBOUNCE_MULTI -- requirements
Module: pb_debounce_multi

Interface
REQ-001 The block SHALL expose parameter N_CH, default 4, number of independent push-button channels (1..32).
REQ-002 The block SHALL expose parameter STABLE_CNT, default 4, qualifying sample count for a level change (1..65535).
REQ-003 The block SHALL expose parameter LONG_CNT, default 1000, sample count of continuous pressed level for a long-press event (1..65535).
REQ-004 The block SHALL expose parameter ACTIVE_LOW, default 1; 1 means a pressed button drives pb_in low.
REQ-005 The block SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-006 The block SHALL have port rst, input, 1 bit; reset rst, asynchronous, active-high; clock clk.
REQ-007 The block SHALL have port ce, input, 1 bit, sample enable; all counting occurs only in clk cycles with ce=1.
REQ-008 The block SHALL have port pb_in, input, N_CH bits, raw asynchronous button levels.
REQ-009 The block SHALL have port pb_level, output, N_CH bits, debounced level, 1=pressed.
REQ-010 The block SHALL have port pb_press, output, N_CH bits, one-clk pulse on debounced press.
REQ-011 The block SHALL have port pb_release, output, N_CH bits, one-clk pulse on debounced release.
REQ-012 The block SHALL have port pb_long, output, N_CH bits, one-clk pulse on long-press qualification.

Function
REQ-013 The block SHALL normalise each pb_in bit to pressed=1 (inverting when ACTIVE_LOW=1), then pass it through a 2-flop synchroniser clocked every clk cycle regardless of ce.
REQ-014 The block SHALL keep per channel a stability counter, width ceil(log2(STABLE_CNT+1)) bits.
REQ-015 In a ce=1 cycle where the synchronised bit equals pb_level[i], the block SHALL clear the stability counter.
REQ-016 In a ce=1 cycle where the bits differ and the counter equals STABLE_CNT-1, the block SHALL load pb_level[i] with the synchronised bit and clear the counter.
REQ-017 In a ce=1 cycle where the bits differ and the counter is below STABLE_CNT-1, the block SHALL increment the counter.
REQ-018 In ce=0 cycles the block SHALL hold all counters and pb_level; pb_press, pb_release and pb_long SHALL be 0.
REQ-019 Latency with ce=1 held and input stable: pb_level[i] SHALL change exactly 2+STABLE_CNT clk cycles after the raw edge is captured.
REQ-020 A glitch shorter than STABLE_CNT ce-samples SHALL NOT change pb_level and SHALL restart qualification from 0.
REQ-021 pb_press[i] SHALL be 1 for exactly the clk cycle in which pb_level[i] first reads 1; pb_release[i] likewise for the first cycle reading 0.
REQ-022 The block SHALL keep per channel a hold counter, width ceil(log2(LONG_CNT+1)) bits; it clears while pb_level[i]=0 and increments on ce=1 while pb_level[i]=1, saturating at LONG_CNT.
REQ-023 pb_long[i] SHALL pulse for one clk cycle when the hold counter transitions to LONG_CNT, at most once per press.
REQ-024 A release before LONG_CNT samples SHALL produce pb_release only, with no pb_long.
REQ-025 Channels SHALL be fully independent; simultaneous events on several channels SHALL produce simultaneous pulses.
REQ-026 All outputs SHALL be registered; there SHALL be no combinational path from pb_in to any output.

Reset
REQ-027 While rst=1 the block SHALL force synchroniser flops, all counters, pb_level, pb_press, pb_release and pb_long to 0, i.e. every channel released.
REQ-028 Assertion of rst mid-qualification or mid-hold SHALL discard progress; after rst deasserts with a button held, a fresh press SHALL be qualified (pb_press after 2+STABLE_CNT cycles).

Verification (N_CH=4, STABLE_CNT=4, LONG_CNT=10, ACTIVE_LOW=1, ce=1 unless stated)
REQ-029 Bench SHALL cover: pb_in[0] driven 1->0 and held -> pb_level[0]=1 and a single pb_press[0] pulse 6 cycles later; other channels remain 0.
REQ-030 Bench SHALL cover: pb_in[1] low for 3 cycles, then high -> no change on pb_level[1] and no pulses.
REQ-031 Bench SHALL cover: pb_in[2] held low for 20 cycles -> pb_press[2] at t+6, pb_long[2] exactly once 10 cycles after pb_press, pb_release[2] 6 cycles after release, no second pb_long.
REQ-032 Bench SHALL cover: ce pulsed every 4th cycle with pb_in[3] held low -> pb_press[3] after 2 sync cycles + 4 ce pulses; pulses appear only in ce=1 cycles.
REQ-033 Bench SHALL cover: rst asserted 2 cycles after pb_press[0] while held, released -> all outputs 0 during rst; pb_press[0] re-fires 6 cycles after rst deasserts.
REQ-034 Bench SHALL cover: all four channels pressed in the same cycle -> pb_press=4'b1111 in a single cycle.

Source files
------------

// File: rtl/pb_debounce_multi.sv
// Multi-channel push-button debouncer: synchronises raw button levels, qualifies
// level changes over STABLE_CNT enabled samples, and emits press/release/long pulses.

module pb_debounce_ch #(
   parameter int STABLE_CNT = 4,
   parameter int LONG_CNT   = 1000,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic ce,
   input  logic pb_raw,
   output logic level_o,
   output logic press_o,
   output logic rel_o,
   output logic long_o
);

   localparam int SW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT + 1) : 1;
   localparam int LW = (LONG_CNT > 1) ? $clog2(LONG_CNT + 1) : 1;
   localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CNT - 1);
   localparam logic [LW-1:0] LONG_MAX    = LW'(LONG_CNT);

   logic          pressed_raw;
   logic          sync1_q, sync2_q;
   logic [SW-1:0] stab_q, stab_d;
   logic [LW-1:0] hold_q, hold_d;
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic          rel_q, rel_d;
   logic          long_q, long_d;

   assign pressed_raw = pb_raw ^ ACTIVE_LOW;

   // Synchroniser runs every clk; only the qualification logic honours ce.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         stab_q  <= '0;
         hold_q  <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
         long_q  <= 1'b0;
      end else begin
         sync1_q <= pressed_raw;
         sync2_q <= sync1_q;
         stab_q  <= stab_d;
         hold_q  <= hold_d;
         level_q <= level_d;
         press_q <= press_d;
         rel_q   <= rel_d;
         long_q  <= long_d;
      end
   end

   always_comb begin
      stab_d  = stab_q;
      hold_d  = hold_q;
      level_d = level_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      long_d  = 1'b0;

      if (ce) begin
         if (sync2_q == level_q) begin
            stab_d = '0;
         end else if (stab_q == STABLE_LAST) begin
            level_d = sync2_q;
            stab_d  = '0;
            press_d = sync2_q;
            rel_d   = ~sync2_q;
         end else begin
            stab_d = stab_q + 1'b1;
         end
      end

      // Hold counter saturates, so the long pulse fires once per press.
      if (!level_q) begin
         hold_d = '0;
      end else if (ce && (hold_q != LONG_MAX)) begin
         hold_d = hold_q + 1'b1;
         long_d = (hold_q == (LONG_MAX - 1'b1));
      end
   end

   assign level_o = level_q;
   assign press_o = press_q;
   assign rel_o   = rel_q;
   assign long_o  = long_q;

endmodule

module pb_debounce_multi #(
   parameter int N_CH       = 4,
   parameter int STABLE_CNT = 4,
   parameter int LONG_CNT   = 1000,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ce,
   input  logic [N_CH-1:0] pb_in,
   output logic [N_CH-1:0] pb_level,
   output logic [N_CH-1:0] pb_press,
   output logic [N_CH-1:0] pb_release,
   output logic [N_CH-1:0] pb_long
);

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      pb_debounce_ch #(
         .STABLE_CNT (STABLE_CNT),
         .LONG_CNT   (LONG_CNT),
         .ACTIVE_LOW (ACTIVE_LOW)
      ) u_ch (
         .clk     (clk),
         .rst     (rst),
         .ce      (ce),
         .pb_raw  (pb_in[g]),
         .level_o (pb_level[g]),
         .press_o (pb_press[g]),
         .rel_o   (pb_release[g]),
         .long_o  (pb_long[g])
      );
   end

endmodule

// File: tb/tb_pb_debounce_multi.sv
// Scoreboard bench for pb_debounce_multi: a sample-window reference model predicts
// every cycle's outputs; directed scenarios additionally check latencies and counts.

module tb_pb_debounce_multi;

   localparam int N_CH       = 4;
   localparam int STABLE_CNT = 4;
   localparam int LONG_CNT   = 10;
   localparam bit ACTIVE_LOW = 1'b1;

   logic            clk = 1'b0;
   logic            rst;
   logic            ce;
   logic [N_CH-1:0] pb_in;
   logic [N_CH-1:0] pb_level, pb_press, pb_release, pb_long;

   always #5 clk = ~clk;

   pb_debounce_multi #(
      .N_CH       (N_CH),
      .STABLE_CNT (STABLE_CNT),
      .LONG_CNT   (LONG_CNT),
      .ACTIVE_LOW (ACTIVE_LOW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ce         (ce),
      .pb_in      (pb_in),
      .pb_level   (pb_level),
      .pb_press   (pb_press),
      .pb_release (pb_release),
      .pb_long    (pb_long)
   );

   typedef struct packed {
      logic [N_CH-1:0] lvl;
      logic [N_CH-1:0] prs;
      logic [N_CH-1:0] rel;
      logic [N_CH-1:0] lng;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference model: a press/release is the moment the last STABLE_CNT enabled
   // samples of the two-cycle-delayed input all disagree with the debounced level.
   logic [N_CH-1:0] m_d1, m_d2, m_lvl, m_raw, m_v;
   int              m_hold[N_CH];
   bit              m_hist[N_CH][$];
   bit              m_ce_last = 1'b1;
   logic            m_pre;
   int              m_nd;

   always @(posedge clk) begin
      exp_t e;
      e = '0;
      cyc++;
      m_ce_last = ce;
      if (rst) begin
         m_d1  = '0;
         m_d2  = '0;
         m_lvl = '0;
         for (int i = 0; i < N_CH; i++) begin
            m_hold[i] = 0;
            m_hist[i].delete();
         end
      end else begin
         m_raw = ACTIVE_LOW ? ~pb_in : pb_in;
         m_v   = m_d2;
         m_d2  = m_d1;
         m_d1  = m_raw;
         for (int i = 0; i < N_CH; i++) begin
            m_pre = m_lvl[i];
            if (ce) begin
               m_hist[i].push_back(m_v[i]);
               if (m_hist[i].size() > STABLE_CNT) void'(m_hist[i].pop_front());
               m_nd = 0;
               for (int k = 0; k < m_hist[i].size(); k++)
                  if (m_hist[i][k] != m_pre) m_nd++;
               if (m_nd == STABLE_CNT) begin
                  m_lvl[i] = m_v[i];
                  e.prs[i] = m_v[i];
                  e.rel[i] = ~m_v[i];
                  m_hist[i].delete();
               end
            end
            if (!m_pre) m_hold[i] = 0;
            else if (ce && m_hold[i] < LONG_CNT) begin
               m_hold[i]++;
               if (m_hold[i] == LONG_CNT) e.lng[i] = 1'b1;
            end
         end
         e.lvl = m_lvl;
      end
      exp_q.push_back(e);
   end

   // Monitor: pops one expectation per cycle and logs pulse events for directed checks.
   int prs_n[N_CH], rel_n[N_CH], lng_n[N_CH];
   int prs_at[N_CH], rel_at[N_CH], lng_at[N_CH];
   int pulse_off_ce = 0;
   bit all_press_seen = 1'b0;

   initial begin
      for (int i = 0; i < N_CH; i++) begin
         prs_n[i] = 0; rel_n[i] = 0; lng_n[i] = 0;
         prs_at[i] = 0; rel_at[i] = 0; lng_at[i] = 0;
      end
   end

   always @(negedge clk) begin
      exp_t e, a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (rst) e = '0;
         a = {pb_level, pb_press, pb_release, pb_long};
         check("outputs{lvl,prs,rel,lng}", 32'(a), 32'(e));
         for (int i = 0; i < N_CH; i++) begin
            if (pb_press[i])   begin prs_n[i]++; prs_at[i] = cyc; end
            if (pb_release[i]) begin rel_n[i]++; rel_at[i] = cyc; end
            if (pb_long[i])    begin lng_n[i]++; lng_at[i] = cyc; end
         end
         if (pb_press == '1) all_press_seen = 1'b1;
         if (((pb_press | pb_release | pb_long) != '0) && !m_ce_last) pulse_off_ce++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      int t0, t1, n0;
      rst   = 1'b1;
      ce    = 1'b1;
      pb_in = '1;
      tick(3);
      check("reset_outputs", 32'({pb_level, pb_press, pb_release, pb_long}), 32'h0);
      rst = 1'b0;
      tick(5);
      check("idle_level", 32'(pb_level), 32'h0);

      // Single press on channel 0.
      t0 = cyc;
      pb_in[0] = 1'b0;
      tick(10);
      check("ch0_press_latency", 32'(prs_at[0] - t0), 32'd6);
      check("ch0_press_count", 32'(prs_n[0]), 32'd1);
      check("ch0_others_quiet", 32'(prs_n[1] + prs_n[2] + prs_n[3]), 32'd0);
      check("ch0_level", 32'(pb_level), 32'h1);
      pb_in[0] = 1'b1;
      tick(10);

      // Three-cycle glitch on channel 1.
      pb_in[1] = 1'b0;
      tick(3);
      pb_in[1] = 1'b1;
      tick(12);
      check("glitch_no_press", 32'(prs_n[1]), 32'd0);
      check("glitch_no_release", 32'(rel_n[1]), 32'd0);
      check("glitch_level", 32'(pb_level[1]), 32'd0);

      // Long press on channel 2.
      t0 = cyc;
      pb_in[2] = 1'b0;
      tick(20);
      t1 = cyc;
      pb_in[2] = 1'b1;
      tick(14);
      check("long_press_latency", 32'(prs_at[2] - t0), 32'd6);
      check("long_after_press", 32'(lng_at[2] - prs_at[2]), 32'd10);
      check("long_once", 32'(lng_n[2]), 32'd1);
      check("long_release_latency", 32'(rel_at[2] - t1), 32'd6);

      // Sparse ce: enabled one cycle in four, channel 3 held pressed then released.
      t0 = cyc;
      for (int k = 0; k < 48; k++) begin
         ce = (k % 4 == 0);
         if (k == 0)  pb_in[3] = 1'b0;
         if (k == 24) pb_in[3] = 1'b1;
         tick(1);
      end
      ce = 1'b1;
      tick(4);
      check("sparse_ce_press_latency", 32'(prs_at[3] - t0), 32'd17);
      check("sparse_ce_release_count", 32'(rel_n[3]), 32'd1);
      check("sparse_ce_no_long", 32'(lng_n[3]), 32'd0);

      // Reset while a press is held.
      n0 = prs_n[0];
      pb_in[0] = 1'b0;
      tick(8);
      rst = 1'b1;
      tick(3);
      check("rst_mid_hold_outputs", 32'({pb_level, pb_press, pb_release, pb_long}), 32'h0);
      t1 = cyc;
      rst = 1'b0;
      tick(10);
      check("rst_refire_latency", 32'(prs_at[0] - t1), 32'd6);
      check("rst_refire_count", 32'(prs_n[0] - n0), 32'd2);
      pb_in[0] = 1'b1;
      tick(10);

      // All channels at once.
      t0 = cyc;
      pb_in = '0;
      tick(10);
      check("all_press_vector", 32'(all_press_seen), 32'd1);
      for (int i = 0; i < N_CH; i++) check("all_press_latency", 32'(prs_at[i] - t0), 32'd6);
      pb_in = '1;
      tick(10);

      // Randomised bounce, sparse ce and occasional reset.
      for (int k = 0; k < 800; k++) begin
         for (int i = 0; i < N_CH; i++)
            if ($urandom_range(0, 11) == 0) pb_in[i] = ~pb_in[i];
         ce  = ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 249) == 0);
         tick(1);
      end
      rst = 1'b0;
      ce  = 1'b1;
      tick(4);
      check("pulses_only_after_ce", 32'(pulse_off_ce), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
